product_writeback: RTL and testbench

Downstream stage of the 8x8 array multiplier. It consumes the 16-bit product and the multiplier's done level, and captures the product on the done rising edge when the multiply opcode is active. It then writes the result into the 8-bit register file as two sequential byte writes, low byte first, and reports completion, overflow and overrun status to the control unit.

---
 rtl/product_writeback.sv | 125 ++++++++++++
 tb/tb_product_writeback.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/product_writeback.sv
// Purpose: captures the multiplier product on a done rising edge and writes it to the register file as two byte writes, low byte first.
// Latency: low-byte write 1 cycle after the capture edge, high-byte write after 2 cycles, done pulse after 3 cycles.
// Backpressure: none; a capture arriving while busy is dropped and sets sticky overrun. Optional accumulate mode: PRODUCT_ACC_EN.
module product_writeback #(
    parameter int          DATA_W = 8,
    parameter int          REG_AW = 3,
    parameter logic [3:0]  MUL_OP = 4'b0100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          ctr,
    input  logic                prod_valid,
    input  logic [2*DATA_W-1:0] prod,
    input  logic [REG_AW-1:0]   dst_lo,
    input  logic [REG_AW-1:0]   dst_hi,
    input  logic                acc_clr,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;

    state_t                state, state_nxt;
    logic                  prev_valid;
    logic [2*DATA_W-1:0]   prod_q;
    logic [REG_AW-1:0]     dst_lo_q, dst_hi_q;
    logic                  cap_evt, capture;
    logic [2*DATA_W-1:0]   result;
    logic                  ovf_nxt;

    assign cap_evt = prod_valid & ~prev_valid & (ctr == MUL_OP);
    assign capture = cap_evt & (state == IDLE);

`ifdef PRODUCT_ACC_EN
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_base;
    logic [2*DATA_W:0]   sum;

    // A clear in the capture cycle makes the result 0 + prod.
    assign acc_base = acc_clr ? '0 : acc;
    assign sum      = {1'b0, acc_base} + {1'b0, prod};
    assign result   = sum[2*DATA_W-1:0];
    assign ovf_nxt  = sum[2*DATA_W] | (|sum[2*DATA_W-1:DATA_W]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (capture) begin
            acc <= result;
        end else if (acc_clr && state == IDLE) begin
            acc <= '0;
        end
    end
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign result  = prod;
    assign ovf_nxt = |prod[2*DATA_W-1:DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_valid <= 1'b1;
            prod_q     <= '0;
            dst_lo_q   <= '0;
            dst_hi_q   <= '0;
            ovf        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_valid <= prod_valid;
            if (capture) begin
                prod_q   <= result;
                dst_lo_q <= dst_lo;
                dst_hi_q <= dst_hi;
                ovf      <= ovf_nxt;
            end
            // Includes the DONE cycle, where the FSM is still leaving busy.
            if (cap_evt && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (capture) state_nxt = WR_LO;
            end
            WR_LO: begin
                busy      = 1'b1;
                rf_we     = 1'b1;
                rf_waddr  = dst_lo_q;
                rf_wdata  = prod_q[DATA_W-1:0];
                state_nxt = WR_HI;
            end
            WR_HI: begin
                busy      = 1'b1;
                rf_we     = 1'b1;
                rf_waddr  = dst_hi_q;
                rf_wdata  = prod_q[2*DATA_W-1:DATA_W];
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_product_writeback.sv
// Directed bench for product_writeback: vector table of single transactions plus hand sequences for overrun, reset and accumulate cases.
module tb_product_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ctr;
    logic        prod_valid;
    logic [15:0] prod;
    logic [2:0]  dst_lo, dst_hi;
    logic        acc_clr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        busy, done, ovf, overrun;

    int tests = 0;
    int fails = 0;
    logic exp_ovf     = 1'b0;
    logic exp_overrun = 1'b0;

    always #5 clk = ~clk;

    product_writeback dut (
        .clk(clk), .rst_n(rst_n), .ctr(ctr), .prod_valid(prod_valid), .prod(prod),
        .dst_lo(dst_lo), .dst_hi(dst_hi), .acc_clr(acc_clr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .ovf(ovf), .overrun(overrun)
    );

    typedef struct {
        logic [15:0] p;
        logic [3:0]  c;
        logic [2:0]  lo;
        logic [2:0]  hi;
        logic        cap;
        logic [7:0]  elo;
        logic [7:0]  ehi;
        logic        eovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, ".we"}, 16'(rf_we), 16'd0);
        check({name, ".addr"}, 16'(rf_waddr), 16'd0);
        check({name, ".data"}, 16'(rf_wdata), 16'd0);
        check({name, ".busy"}, 16'(busy), 16'd0);
        check({name, ".done"}, 16'(done), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; prod_valid = 1'b0; acc_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ovf = 1'b0;
        exp_overrun = 1'b0;
    endtask

    // Setup cycle (optional acc_clr), rising prod_valid, then three busy cycles and one idle cycle.
    task automatic run_txn(input logic [15:0] p, input logic [3:0] c, input logic [2:0] lo,
                           input logic [2:0] hi, input logic clr, input logic cap,
                           input logic [7:0] elo, input logic [7:0] ehi, input logic eovf);
        @(negedge clk);
        ctr = c; prod = p; dst_lo = lo; dst_hi = hi; prod_valid = 1'b0; acc_clr = clr;
        @(negedge clk);
        prod_valid = 1'b1; acc_clr = 1'b0;
        @(negedge clk);
        prod_valid = 1'b0;
        if (cap) begin
            check("wr_lo.we", 16'(rf_we), 16'd1);
            check("wr_lo.addr", 16'(rf_waddr), 16'(lo));
            check("wr_lo.data", 16'(rf_wdata), 16'(elo));
            check("wr_lo.busy", 16'(busy), 16'd1);
        end else begin
            check_idle("nocap1");
        end
        @(negedge clk);
        if (cap) begin
            check("wr_hi.we", 16'(rf_we), 16'd1);
            check("wr_hi.addr", 16'(rf_waddr), 16'(hi));
            check("wr_hi.data", 16'(rf_wdata), 16'(ehi));
            check("wr_hi.busy", 16'(busy), 16'd1);
        end else begin
            check_idle("nocap2");
        end
        @(negedge clk);
        if (cap) begin
            exp_ovf = eovf;
            check("done.done", 16'(done), 16'd1);
            check("done.we", 16'(rf_we), 16'd0);
            check("done.busy", 16'(busy), 16'd1);
        end else begin
            check_idle("nocap3");
        end
        check("ovf", 16'(ovf), 16'(exp_ovf));
        check("overrun", 16'(overrun), 16'(exp_overrun));
        @(negedge clk);
        check_idle("after");
    endtask

    initial begin
        rst_n = 1'b0; ctr = 4'd0; prod_valid = 1'b1; prod = 16'd0;
        dst_lo = 3'd0; dst_hi = 3'd0; acc_clr = 1'b0;

        vecs[0] = '{16'h03A8, 4'b0100, 3'd2, 3'd3, 1'b1, 8'hA8, 8'h03, 1'b1};
        vecs[1] = '{16'h0042, 4'b0100, 3'd5, 3'd6, 1'b1, 8'h42, 8'h00, 1'b0};
        vecs[2] = '{16'h1234, 4'b0011, 3'd1, 3'd2, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{16'hBEEF, 4'b0100, 3'd7, 3'd7, 1'b1, 8'hEF, 8'hBE, 1'b1};
        vecs[4] = '{16'h00FF, 4'b0100, 3'd0, 3'd1, 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{16'h0100, 4'b0100, 3'd4, 3'd5, 1'b1, 8'h00, 8'h01, 1'b1};

        // Reset state, with prod_valid held high through release.
        @(negedge clk);
        @(negedge clk);
        check_idle("rst");
        check("rst.ovf", 16'(ovf), 16'd0);
        check("rst.overrun", 16'(overrun), 16'd0);
        rst_n = 1'b1; ctr = 4'b0100;
        @(negedge clk);
        check_idle("rst_rel");
        prod_valid = 1'b0;

        foreach (vecs[i])
            run_txn(vecs[i].p, vecs[i].c, vecs[i].lo, vecs[i].hi, 1'b1,
                    vecs[i].cap, vecs[i].elo, vecs[i].ehi, vecs[i].eovf);

        // Rise with wrong opcode, then opcode changes while prod_valid stays high.
        @(negedge clk);
        ctr = 4'b0011; prod_valid = 1'b1;
        @(negedge clk);
        ctr = 4'b0100;
        @(negedge clk);
        check_idle("ctrchg1");
        @(negedge clk);
        check_idle("ctrchg2");
        check("ctrchg.overrun", 16'(overrun), 16'd0);
        prod_valid = 1'b0;

        // Second rise lands in WR_HI: dropped, overrun set and sticky.
        @(negedge clk);
        prod = 16'h0201; dst_lo = 3'd1; dst_hi = 3'd2; prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        check("ovr.lo_data", 16'(rf_wdata), 16'h01);
        @(negedge clk);
        prod_valid = 1'b1;
        check("ovr.hi_data", 16'(rf_wdata), 16'h02);
        @(negedge clk);
        prod_valid = 1'b0;
        check("ovr.done", 16'(done), 16'd1);
        check("ovr.overrun", 16'(overrun), 16'd1);
        @(negedge clk);
        check_idle("ovr.idle");
        exp_overrun = 1'b1;
        run_txn(16'h0011, 4'b0100, 3'd3, 3'd4, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0);
        do_reset();
        @(negedge clk);
        check("ovr.cleared", 16'(overrun), 16'd0);

        // Rise during the DONE cycle is dropped too.
        prod = 16'h0077; dst_lo = 3'd6; dst_hi = 3'd7; prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("dcap.done", 16'(done), 16'd1);
        prod_valid = 1'b1;
        @(negedge clk);
        check_idle("dcap1");
        check("dcap.overrun", 16'(overrun), 16'd1);
        @(negedge clk);
        check_idle("dcap2");
        prod_valid = 1'b0;

        // Reset at the edge that would start the high-byte write.
        do_reset();
        @(negedge clk);
        prod = 16'h5A5A; dst_lo = 3'd2; dst_hi = 3'd5; prod_valid = 1'b1;
        @(negedge clk);
        check("mid.lo_we", 16'(rf_we), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid.rst");
        check("mid.ovf", 16'(ovf), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("mid.rel1");
        @(negedge clk);
        check_idle("mid.rel2");
        prod_valid = 1'b0;

`ifdef PRODUCT_ACC_EN
        do_reset();
        run_txn(16'h8000, 4'b0100, 3'd0, 3'd1, 1'b0, 1'b1, 8'h00, 8'h80, 1'b1);
        run_txn(16'h8001, 4'b0100, 3'd2, 3'd3, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1);
        run_txn(16'h0005, 4'b0100, 3'd4, 3'd5, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
